// File: rtl/ram_reader_pkg.sv
// ============================================================================
// Module   : ram_reader_pkg
// Purpose  : Shared constants, typedefs and helpers for the RAM burst reader.
//            The address/count/data typedefs describe the default build
//            (5-bit address, 8-byte words, 6-bit count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_reader_pkg;

  // Output buffer depth; the issue credit is sized against it.
  localparam int FIFO_DEPTH  = 4;
  localparam int PTR_NBITS   = 2;
  localparam int LEVEL_NBITS = 3;

  // Default configuration widths.
  localparam int DEF_ADDR_NBITS  = 5;
  localparam int DEF_SPAN_NBITS  = 8;
  localparam int DEF_COUNT_NBITS = 6;

  typedef logic [DEF_ADDR_NBITS-1:0]    addr_t;
  typedef logic [DEF_COUNT_NBITS-1:0]   count_t;
  typedef logic [DEF_SPAN_NBITS*8-1:0]  data_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } fifo_entry_t;

  // Credit already committed: words buffered plus words still in the RAM pipe.
  function automatic logic [LEVEL_NBITS:0] credit_used(
    input logic [LEVEL_NBITS-1:0] level,
    input logic [1:0]             inflight
  );
    return {1'b0, level} + {2'b00, inflight};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_reader_fifo.sv
// ============================================================================
// Module   : ram_reader_fifo
// Purpose  : 4-entry single-clock FIFO with level output and synchronous
//            flush. Head entry is presented directly from storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_reader_fifo
  import ram_reader_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [LEVEL_NBITS-1:0] o_level
);

  logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_NBITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_NBITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_NBITS-1:0] level_q, level_d;
  logic                   do_push;
  logic                   do_pop;

  // Next-state: push/pop bookkeeping; flush overrides pointer and level updates.
  always_comb begin
    do_pop   = i_pop && (level_q != '0);
    do_push  = i_push && ((level_q != LEVEL_NBITS'(FIFO_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + PTR_NBITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_NBITS'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LEVEL_NBITS'(1);
      2'b01:   level_d = level_q - LEVEL_NBITS'(1);
      default: level_d = level_q;
    endcase
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

`default_nettype wire

// File: rtl/ram_burst_reader.sv
// ============================================================================
// Module   : ram_burst_reader
// Purpose  : Burst read initiator for a block RAM with a 1-cycle registered
//            read port. Issues addresses under FIFO credit, tracks the two
//            in-flight pipeline stages and streams words out over
//            valid/ready with per-burst last marking.
// Options  : RAM_BURST_READER_ABORT_EN - adds abort_in, which flushes the
//            burst, the in-flight words and the output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_NBITS  = 5,
  parameter int SPAN_NBITS  = 8,
  parameter int COUNT_NBITS = 6
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
`ifdef RAM_BURST_READER_ABORT_EN
  input  logic                    abort_in,
`endif
  input  logic                    cmdValid_in,
  output logic                    cmdReady_out,
  input  logic [ADDR_NBITS-1:0]   cmdAddr_in,
  input  logic [COUNT_NBITS-1:0]  cmdCount_in,
  output logic [ADDR_NBITS-1:0]   ramReadAddr_out,
  input  logic [SPAN_NBITS*8-1:0] ramReadData_in,
  output logic                    rspValid_out,
  input  logic                    rspReady_in,
  output logic [SPAN_NBITS*8-1:0] rspData_out,
  output logic                    rspLast_out,
  output logic                    busy_out
);

  localparam int DATA_NBITS  = SPAN_NBITS * 8;
  localparam int ENTRY_NBITS = DATA_NBITS + 1;

  logic [COUNT_NBITS-1:0] remaining_q, remaining_d;
  logic [ADDR_NBITS-1:0]  next_addr_q, next_addr_d;
  logic [ADDR_NBITS-1:0]  rd_addr_q, rd_addr_d;
  // Stage 1: address presented to RAM; stage 2: RAM data valid on input.
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_last_q, s2_last_d;

  logic                   abort;
  logic                   cmd_fire;
  logic                   credit_ok;
  logic [1:0]             inflight;
  logic                   src_valid;
  logic [ADDR_NBITS-1:0]  src_addr;
  logic [COUNT_NBITS-1:0] src_count;
  logic                   issue;

  logic [ENTRY_NBITS-1:0] fifo_head;
  logic [LEVEL_NBITS-1:0] fifo_level;
  logic                   fifo_push;
  logic                   fifo_pop;

`ifdef RAM_BURST_READER_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  assign credit_ok = credit_used(fifo_level, inflight) < (LEVEL_NBITS+1)'(FIFO_DEPTH);

  // Issue/credit logic: a freshly accepted command issues its first word on
  // the acceptance edge so its address appears the very next cycle.
  always_comb begin
    cmd_fire  = cmdValid_in && (remaining_q == '0);
    src_valid = 1'b0;
    src_addr  = next_addr_q;
    src_count = remaining_q;
    if (remaining_q != '0) begin
      src_valid = 1'b1;
    end else if (cmd_fire && (cmdCount_in != '0)) begin
      src_valid = 1'b1;
      src_addr  = cmdAddr_in;
      src_count = cmdCount_in;
    end
    issue = src_valid && credit_ok && !abort;

    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    rd_addr_d   = rd_addr_q;
    if (cmd_fire) begin
      remaining_d = cmdCount_in;
      next_addr_d = cmdAddr_in;
    end
    if (issue) begin
      rd_addr_d   = src_addr;
      next_addr_d = src_addr + ADDR_NBITS'(1);
      remaining_d = src_count - COUNT_NBITS'(1);
    end

    s1_valid_d = issue;
    s1_last_d  = issue && (src_count == COUNT_NBITS'(1));
    s2_valid_d = s1_valid_q && !abort;
    s2_last_d  = s1_last_q;

    // Abort wins over everything, including a same-edge command.
    if (abort) begin
      remaining_d = '0;
      next_addr_d = next_addr_q;
    end
  end

  // Burst and pipeline registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      remaining_q <= '0;
      next_addr_q <= '0;
      rd_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      rd_addr_q   <= rd_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
    end
  end

  assign fifo_push = s2_valid_q && !abort;
  assign fifo_pop  = rspValid_out && rspReady_in;

  ram_reader_fifo #(
    .WIDTH (ENTRY_NBITS)
  ) u_fifo (
    .clk         (clk_in),
    .rst         (reset_in),
    .i_clr       (abort),
    .i_push      (fifo_push),
    .i_push_data ({ramReadData_in, s2_last_q}),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_level     (fifo_level)
  );

  // Response side is driven purely from registered FIFO state; data is
  // forced to zero when nothing is buffered.
  always_comb begin
    rspValid_out = (fifo_level != '0);
    rspData_out  = rspValid_out ? fifo_head[ENTRY_NBITS-1:1] : '0;
    rspLast_out  = rspValid_out && fifo_head[0];
  end

  assign cmdReady_out    = (remaining_q == '0);
  assign ramReadAddr_out = rd_addr_q;
  assign busy_out        = (remaining_q != '0) || s1_valid_q || s2_valid_q || (fifo_level != '0);

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
// ============================================================================
// Module   : tb_ram_burst_reader
// Purpose  : Self-checking bench for ram_burst_reader. A behavioural RAM and
//            an expected-word queue (filled from accepted commands) are
//            compared against every response handshake; directed scenarios
//            pin latency, wrap, backpressure, reset and abort behaviour.
// Options  : RAM_BURST_READER_ABORT_EN - enables the abort scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_reader;
  import ram_reader_pkg::*;

  localparam int NWORDS = 32;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        abort_in = 1'b0;
  logic        cmdValid_in = 1'b0;
  logic        cmdReady_out;
  addr_t       cmdAddr_in = '0;
  count_t      cmdCount_in = '0;
  addr_t       ramReadAddr_out;
  data_t       ramReadData_in;
  logic        rspValid_out;
  logic        rspReady_in = 1'b0;
  data_t       rspData_out;
  logic        rspLast_out;
  logic        busy_out;

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;

  data_t ram_mem [NWORDS];

  typedef struct {
    data_t data;
    logic  last;
  } exp_t;
  exp_t  expq [$];
  exp_t  e;
  data_t popped_data [$];
  logic  popped_last [$];

  always #5 clk_in = ~clk_in;

  ram_burst_reader #(
    .ADDR_NBITS  (5),
    .SPAN_NBITS  (8),
    .COUNT_NBITS (6)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
`ifdef RAM_BURST_READER_ABORT_EN
    .abort_in        (abort_in),
`endif
    .cmdValid_in     (cmdValid_in),
    .cmdReady_out    (cmdReady_out),
    .cmdAddr_in      (cmdAddr_in),
    .cmdCount_in     (cmdCount_in),
    .ramReadAddr_out (ramReadAddr_out),
    .ramReadData_in  (ramReadData_in),
    .rspValid_out    (rspValid_out),
    .rspReady_in     (rspReady_in),
    .rspData_out     (rspData_out),
    .rspLast_out     (rspLast_out),
    .busy_out        (busy_out)
  );

  // Behavioural RAM: registered read, one cycle latency.
  always @(posedge clk_in) ramReadData_in <= ram_mem[ramReadAddr_out];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: sampled mid-cycle, mirrors the handshakes of the coming edge.
  always @(negedge clk_in) begin
    if (reset_in) begin
      expq.delete();
    end else begin
      if (!rspValid_out) chk("last_without_valid", rspLast_out, 1'b0);
      if (rspValid_out && rspReady_in) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("rsp_data", rspData_out, e.data);
          chk("rsp_last", rspLast_out, e.last);
        end
        popped_data.push_back(rspData_out);
        popped_last.push_back(rspLast_out);
      end
      if (abort_in) begin
        expq.delete();
      end else if (cmdValid_in && cmdReady_out) begin
        for (int i = 0; i < int'(cmdCount_in); i++) begin
          exp_t n;
          addr_t a;
          a      = cmdAddr_in + addr_t'(i);
          n.data = ram_mem[a];
          n.last = (i == int'(cmdCount_in) - 1);
          expq.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rand_ready) rspReady_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic fill_ram();
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = {$urandom, $urandom};
  endtask

  task automatic send_cmd(input addr_t a, input count_t c);
    int  n = 0;
    bit  done = 1'b0;
    cmdAddr_in  = a;
    cmdCount_in = c;
    cmdValid_in = 1'b1;
    while (!done) begin
      @(negedge clk_in);
      if (cmdReady_out) done = 1'b1;
      tick();
      n++;
      if (!done && n > 1000) begin
        chk("cmd_accept_timeout", 1'b1, 1'b0);
        done = 1'b1;
      end
    end
    cmdValid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  done = 1'b0;
    while (!done) begin
      @(negedge clk_in);
      if (!busy_out && expq.size() == 0) done = 1'b1;
      else begin
        tick();
        n++;
        if (n > 3000) begin
          chk("idle_timeout", 1'b1, 1'b0);
          done = 1'b1;
        end
      end
    end
    tick();
  endtask

  initial begin
    logic [4:0] lp;
    fill_ram();
    repeat (3) tick();
    reset_in = 1'b0;

    // Reset values (cycle k).
    chk("rst_cmd_ready", cmdReady_out, 1'b1);
    chk("rst_rsp_valid", rspValid_out, 1'b0);
    chk("rst_rsp_last", rspLast_out, 1'b0);
    chk("rst_rsp_data", rspData_out, 64'h0);
    chk("rst_ram_addr", ramReadAddr_out, 5'd0);
    chk("rst_busy", busy_out, 1'b0);

    // Burst addr=3 count=4 with consumer ready: exact latency and throughput.
    rspReady_in = 1'b1;
    cmdAddr_in = 5'd3; cmdCount_in = 6'd4; cmdValid_in = 1'b1;
    tick();
    cmdValid_in = 1'b0;
    chk("t1_addr_k1", ramReadAddr_out, 5'd3);
    chk("t1_ready_k1", cmdReady_out, 1'b0);
    tick();
    chk("t1_addr_k2", ramReadAddr_out, 5'd4);
    chk("t1_valid_k2", rspValid_out, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", rspValid_out, 1'b1);
      chk("t1_data", rspData_out, ram_mem[3 + i]);
      chk("t1_last", rspLast_out, (i == 3));
    end
    tick();
    chk("t1_busy_after", busy_out, 1'b0);
    chk("t1_valid_after", rspValid_out, 1'b0);
    chk("t1_addr_hold", ramReadAddr_out, 5'd6);

    // Wrap-around burst.
    popped_data.delete(); popped_last.delete();
    send_cmd(5'd30, 6'd4);
    wait_idle();
    chk("t2_count", popped_data.size(), 4);
    chk("t2_word2_is_addr0", popped_data[2], ram_mem[0]);
    chk("t2_word3_is_addr1", popped_data[3], ram_mem[1]);

    // Backpressure: at most 4 words buffered, issue stalls.
    popped_data.delete(); popped_last.delete();
    rspReady_in = 1'b0;
    send_cmd(5'd12, 6'd8);
    repeat (10) tick();
    chk("t3_addr_stalled", ramReadAddr_out, 5'd15);
    chk("t3_valid", rspValid_out, 1'b1);
    chk("t3_cmd_ready", cmdReady_out, 1'b0);
    chk("t3_busy", busy_out, 1'b1);
    rspReady_in = 1'b1;
    wait_idle();
    chk("t3_count", popped_data.size(), 8);

    // Back-to-back commands, then a zero-length command.
    popped_data.delete(); popped_last.delete();
    send_cmd(5'd0, 6'd2);
    send_cmd(5'd10, 6'd3);
    wait_idle();
    chk("t4_count", popped_last.size(), 5);
    lp = '0;
    for (int i = 0; i < 5 && i < popped_last.size(); i++) lp[i] = popped_last[i];
    chk("t4_last_pattern", lp, 5'b10010);
    if (popped_data.size() == 5) begin
      chk("t4_word2", popped_data[2], ram_mem[10]);
      chk("t4_word4", popped_data[4], ram_mem[12]);
    end
    popped_data.delete(); popped_last.delete();
    send_cmd(5'd5, 6'd0);
    repeat (4) begin
      chk("t4_zero_ready", cmdReady_out, 1'b1);
      chk("t4_zero_valid", rspValid_out, 1'b0);
      chk("t4_zero_busy", busy_out, 1'b0);
      tick();
    end
    chk("t4_zero_count", popped_data.size(), 0);

    // Reset mid-burst with two words in flight.
    cmdAddr_in = 5'd20; cmdCount_in = 6'd6; cmdValid_in = 1'b1;
    tick();
    cmdValid_in = 1'b0;
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk("t5_valid", rspValid_out, 1'b0);
    chk("t5_busy", busy_out, 1'b0);
    chk("t5_cmd_ready", cmdReady_out, 1'b1);
    chk("t5_addr", ramReadAddr_out, 5'd0);
    repeat (5) begin
      tick();
      chk("t5_no_stale", rspValid_out, 1'b0);
    end

`ifdef RAM_BURST_READER_ABORT_EN
    // Abort with a full buffer and a simultaneous command.
    rspReady_in = 1'b0;
    send_cmd(5'd8, 6'd4);
    repeat (8) tick();
    chk("t6_full_valid", rspValid_out, 1'b1);
    chk("t6_full_ready", cmdReady_out, 1'b1);
    abort_in = 1'b1;
    cmdAddr_in = 5'd1; cmdCount_in = 6'd3; cmdValid_in = 1'b1;
    tick();
    abort_in = 1'b0;
    cmdValid_in = 1'b0;
    chk("t6_valid", rspValid_out, 1'b0);
    chk("t6_cmd_ready", cmdReady_out, 1'b1);
    chk("t6_busy", busy_out, 1'b0);
    repeat (4) begin
      tick();
      chk("t6_stays_idle", rspValid_out, 1'b0);
      chk("t6_addr_hold", ramReadAddr_out, 5'd11);
    end
    rspReady_in = 1'b1;
`endif

    // Randomised commands against the model with random backpressure.
    fill_ram();
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0)
        send_cmd(addr_t'($urandom), count_t'($urandom_range(13, 40)));
      else
        send_cmd(addr_t'($urandom), count_t'($urandom_range(0, 12)));
    end
    rand_ready = 1'b0;
    rspReady_in = 1'b1;
    wait_idle();
    chk("final_queue_empty", expq.size(), 0);
    chk("final_busy", busy_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side initiator for the single-clock byte-enable block RAM, which has a registered read port with 1-cycle latency. Accepts burst commands (start address + word count), drives the RAM read address, absorbs the RAM read latency, and streams the read words out over a valid/ready interface with full backpressure. Sits between the RAM's read port and the TLP/DMA egress logic, opposite the byte-enabled write path.

## Interface
- ADDR_NBITS, 5, RAM address width; addresses wrap modulo 2**ADDR_NBITS
- SPAN_NBITS, 8, bytes per RAM word; data width is SPAN_NBITS×8
- COUNT_NBITS, 6, width of burst word count
- clk_in  input  1  sole clock, all state on rising edge
- reset_in  input  1  synchronous, active-high reset
- cmdValid_in  input  1  command offered
- cmdReady_out  output  1  command can be accepted
- cmdAddr_in  input  ADDR_NBITS  first word address
- cmdCount_in  input  COUNT_NBITS  number of words; 0 is legal and produces nothing
- ramReadAddr_out  output  ADDR_NBITS  registered RAM read address
- ramReadData_in  input  SPAN_NBITS×8  RAM read data, valid one cycle after address
- rspValid_out  output  1  response word available
- rspReady_in  input  1  consumer accepts word
- rspData_out  output  SPAN_NBITS×8  response word
- rspLast_out  output  1  final word of the current burst
- busy_out  output  1  words remain to issue, in flight, or buffered
- abort_in  input  1  only when RAM_BURST_READER_ABORT_EN is defined

## Operation
- State: remaining (COUNT_NBITS), nextAddr, inflight (0..2), 4-entry output FIFO of {data, last}
- Command handshake: cmdValid_in & cmdReady_out at an edge; loads nextAddr=cmdAddr_in, remaining=cmdCount_in
- cmdReady_out = (remaining == 0); new command may be accepted while the previous burst is still draining
- Issue: when remaining != 0 and fifoLevel + inflight < 4, register ramReadAddr_out=nextAddr, tag last=(remaining==1), nextAddr++ (wraps 2**ADDR_NBITS-1 -> 0), remaining--
- Issued word spends the address stage, then the RAM stage; ramReadData_in is written into the FIFO with its tag at the end of the RAM stage
- FIFO pop on rspValid_out & rspReady_in; push and pop in the same cycle leave level unchanged
- rspLast_out travels with its word; never asserted for count 0
- rspValid_out, rspData_out, rspLast_out driven from the FIFO head (registered, no combinational path from rspReady_in to ramReadAddr_out)
- FIFO never overflows: issue credit covers all in-flight words
- ramReadAddr_out holds its last value when not issuing

## Timing
- Reset values: cmdReady_out=1 (after reset), rspValid_out=0, rspLast_out=0, rspData_out=0, ramReadAddr_out=0, busy_out=0, inflight=0, FIFO empty
- Command handshake in cycle k: ramReadAddr_out=cmdAddr_in in cycle k+1; rspValid_out high in cycle k+3
- With rspReady_in held high: one word per cycle sustained, no bubbles
- rspReady_in low: at most 4 words buffered; issuing stalls, resumes the cycle after a pop frees credit
- reset_in mid-burst: all state cleared next cycle; RAM data in flight is discarded

## Configuration
- RAM_BURST_READER_ABORT_EN defined: abort_in port present. abort_in high at an edge clears remaining, inflight and the FIFO. Next cycle: rspValid_out=0, cmdReady_out=1, busy_out=0. abort_in has priority over a simultaneous command handshake, which is dropped.
- Not defined: port absent; bursts always run to completion.

## Structure
- Package ram_reader_pkg: FIFO_DEPTH=4, typedef for the {data, last} FIFO entry, and the address/count typedefs derived from the parameters
- One sub-module: ram_reader_fifo, a 4-entry single-clock FIFO with level output; the issue/credit logic stays in the top module

## Test plan
- Reset, then cmd addr=3 count=4 with rspReady=1 -> words from addresses 3,4,5,6 on consecutive cycles from k+3; rspLast only on the address-6 word; busy_out falls after the last pop
- cmd addr=30 count=4, ADDR_NBITS=5 -> reads 30,31,0,1 (wrap-around)
- count=8 with rspReady low for 10 cycles, then high -> exactly 4 words buffered, no loss or duplication, all 8 delivered in order
- Back-to-back cmds (0,2) and (10,3), second accepted once remaining hits 0 -> stream 0,1,10,11,12; rspLast on words 1 and 12; count=0 cmd -> no output, cmdReady stays 1
- reset_in pulsed mid-burst with 2 words in flight -> rspValid=0 next cycle, no stale word after reset
- ABORT_EN: abort with FIFO full and a simultaneous cmd -> FIFO flushed, cmd dropped, idle next cycle
